// File: rtl/reg_file_rename_pkg.sv
// rtl/reg_file_rename_pkg.sv - shared widths for the rename register file
package reg_file_rename_pkg;
  localparam int REG_POS_WID = 5;
  localparam int NREG        = 1 << REG_POS_WID;
  localparam int ROB_SIZE    = 16;
  localparam int ROB_POS_WID = $clog2(ROB_SIZE);
  localparam int XLEN        = 32;
endpackage

// File: rtl/reg_file_rename_if.sv
// rtl/reg_file_rename_if.sv - issue/read/commit bus of the rename register file
interface reg_file_rename_if;
  import reg_file_rename_pkg::*;

  logic                   i_rdy;
  logic                   i_rollback;
  logic                   i_issue;
  logic [REG_POS_WID-1:0] i_issue_rd;
  logic [ROB_POS_WID-1:0] i_issue_rob_pos;
  logic [REG_POS_WID-1:0] i_rs1;
  logic [REG_POS_WID-1:0] i_rs2;
  logic [XLEN-1:0]        o_rs1_val;
  logic [XLEN-1:0]        o_rs2_val;
  logic                   o_rs1_busy;
  logic                   o_rs2_busy;
  logic [ROB_POS_WID-1:0] o_rs1_rob_pos;
  logic [ROB_POS_WID-1:0] o_rs2_rob_pos;
  logic                   i_reg_write;
  logic [REG_POS_WID-1:0] i_reg_rd;
  logic [XLEN-1:0]        i_reg_val;
  logic [ROB_POS_WID-1:0] i_commit_rob_pos;

  modport master (
    output i_rdy, i_rollback, i_issue, i_issue_rd, i_issue_rob_pos, i_rs1, i_rs2,
           i_reg_write, i_reg_rd, i_reg_val, i_commit_rob_pos,
    input  o_rs1_val, o_rs2_val, o_rs1_busy, o_rs2_busy, o_rs1_rob_pos, o_rs2_rob_pos
  );

  modport slave (
    input  i_rdy, i_rollback, i_issue, i_issue_rd, i_issue_rob_pos, i_rs1, i_rs2,
           i_reg_write, i_reg_rd, i_reg_val, i_commit_rob_pos,
    output o_rs1_val, o_rs2_val, o_rs1_busy, o_rs2_busy, o_rs1_rob_pos, o_rs2_rob_pos
  );
endinterface

// File: rtl/reg_file_rename_read_port.sv
// rtl/reg_file_rename_read_port.sv - one source read: x0 check, commit bypass, output mux
module reg_file_rename_read_port
  import reg_file_rename_pkg::*;
(
  input  logic [REG_POS_WID-1:0] i_rs,
  input  logic [XLEN-1:0]        i_arr_val,
  input  logic                   i_arr_busy,
  input  logic [ROB_POS_WID-1:0] i_arr_tag,
  input  logic                   i_reg_write,
  input  logic [REG_POS_WID-1:0] i_reg_rd,
  input  logic [XLEN-1:0]        i_reg_val,
  input  logic [ROB_POS_WID-1:0] i_commit_rob_pos,
  output logic [XLEN-1:0]        o_val,
  output logic                   o_busy,
  output logic [ROB_POS_WID-1:0] o_rob_pos
);
  logic w_is_x0;
  logic w_bypass;

  // Bypass only when the committing slot is the one this register still waits on.
  assign w_is_x0  = (i_rs == '0);
  assign w_bypass = i_arr_busy && i_reg_write && (i_reg_rd == i_rs) && (i_arr_tag == i_commit_rob_pos);

  always_comb begin
    o_val     = i_arr_val;
    o_busy    = i_arr_busy;
    o_rob_pos = i_arr_tag;
    if (w_is_x0) begin
      o_val     = '0;
      o_busy    = 1'b0;
      o_rob_pos = '0;
    end else if (w_bypass) begin
      o_val  = i_reg_val;
      o_busy = 1'b0;
    end
  end
endmodule

// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with per-register ROB rename tags
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  reg_file_rename_if.slave  bus
);
  logic [XLEN-1:0]        r_val  [NREG];
  logic                   r_busy [NREG];
  logic [ROB_POS_WID-1:0] r_tag  [NREG];

  logic w_commit;
  logic w_issue;
  logic w_issue_hits_commit;

  assign w_commit            = bus.i_reg_write && (bus.i_reg_rd != '0);
  assign w_issue             = bus.i_issue && (bus.i_issue_rd != '0) && !bus.i_rollback;
  assign w_issue_hits_commit = w_issue && (bus.i_issue_rd == bus.i_reg_rd);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_val[i]  <= '0;
        r_busy[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else if (bus.i_rdy) begin
      if (w_commit) begin
        r_val[bus.i_reg_rd] <= bus.i_reg_val;
        if ((r_tag[bus.i_reg_rd] == bus.i_commit_rob_pos) && !w_issue_hits_commit)
          r_busy[bus.i_reg_rd] <= 1'b0;
      end
      // Rollback drops every mapping; a concurrent commit above still lands its value.
      if (bus.i_rollback) begin
        for (int i = 0; i < NREG; i++)
          r_busy[i] <= 1'b0;
      end else if (w_issue) begin
        r_busy[bus.i_issue_rd] <= 1'b1;
        r_tag[bus.i_issue_rd]  <= bus.i_issue_rob_pos;
      end
    end
  end

  reg_file_rename_read_port u_rs1 (
    .i_rs             (bus.i_rs1),
    .i_arr_val        (r_val[bus.i_rs1]),
    .i_arr_busy       (r_busy[bus.i_rs1]),
    .i_arr_tag        (r_tag[bus.i_rs1]),
    .i_reg_write      (bus.i_reg_write),
    .i_reg_rd         (bus.i_reg_rd),
    .i_reg_val        (bus.i_reg_val),
    .i_commit_rob_pos (bus.i_commit_rob_pos),
    .o_val            (bus.o_rs1_val),
    .o_busy           (bus.o_rs1_busy),
    .o_rob_pos        (bus.o_rs1_rob_pos)
  );

  reg_file_rename_read_port u_rs2 (
    .i_rs             (bus.i_rs2),
    .i_arr_val        (r_val[bus.i_rs2]),
    .i_arr_busy       (r_busy[bus.i_rs2]),
    .i_arr_tag        (r_tag[bus.i_rs2]),
    .i_reg_write      (bus.i_reg_write),
    .i_reg_rd         (bus.i_reg_rd),
    .i_reg_val        (bus.i_reg_val),
    .i_commit_rob_pos (bus.i_commit_rob_pos),
    .o_val            (bus.o_rs2_val),
    .o_busy           (bus.o_rs2_busy),
    .o_rob_pos        (bus.o_rs2_rob_pos)
  );
endmodule

// File: tb/tb_reg_file_rename.sv
// tb/tb_reg_file_rename.sv - directed vectors plus randomized check against a mapping model
module tb_reg_file_rename;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  reg_file_rename_if bus ();

  reg_file_rename dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rb;
    logic        iss;
    logic [4:0]  ird;
    logic [3:0]  ipos;
    logic [4:0]  rs;
    logic        wr;
    logic [4:0]  wrd;
    logic [31:0] wval;
    logic [3:0]  cpos;
    logic [31:0] e_val;
    logic        e_busy;
    logic [3:0]  e_pos;
  } vec_t;

  vec_t tbl[$];

  // Reference: committed value per register and the ROB slot it waits on (-1 = none).
  logic [31:0] m_val  [32];
  int          m_pend [32];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_port(input string name, input logic [31:0] v, input logic b, input logic [3:0] p,
                          input logic [31:0] ev, input logic eb, input logic [3:0] ep, input logic chk_pos);
    cmp({name, ".val"}, v, ev);
    cmp({name, ".busy"}, {31'd0, b}, {31'd0, eb});
    if (chk_pos) cmp({name, ".rob_pos"}, {28'd0, p}, {28'd0, ep});
  endtask

  task automatic idle();
    bus.i_rdy = 1'b1; bus.i_rollback = 1'b0; bus.i_issue = 1'b0; bus.i_issue_rd = '0;
    bus.i_issue_rob_pos = '0; bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_reg_write = 1'b0;
    bus.i_reg_rd = '0; bus.i_reg_val = '0; bus.i_commit_rob_pos = '0;
  endtask

  task automatic add(input logic rdy, input logic rb, input logic iss, input logic [4:0] ird,
                     input logic [3:0] ipos, input logic [4:0] rs, input logic wr, input logic [4:0] wrd,
                     input logic [31:0] wval, input logic [3:0] cpos, input logic [31:0] ev,
                     input logic eb, input logic [3:0] ep);
    vec_t v;
    v.rdy = rdy; v.rb = rb; v.iss = iss; v.ird = ird; v.ipos = ipos; v.rs = rs;
    v.wr = wr; v.wrd = wrd; v.wval = wval; v.cpos = cpos; v.e_val = ev; v.e_busy = eb; v.e_pos = ep;
    tbl.push_back(v);
  endtask

  task automatic model_tick();
    int rd;
    if (bus.i_rdy) begin
      rd = int'(bus.i_reg_rd);
      if (bus.i_reg_write && rd != 0) begin
        m_val[rd] = bus.i_reg_val;
        if (m_pend[rd] == int'(bus.i_commit_rob_pos)) m_pend[rd] = -1;
      end
      if (bus.i_rollback) begin
        for (int i = 0; i < 32; i++) m_pend[i] = -1;
      end else if (bus.i_issue && bus.i_issue_rd != 0) begin
        m_pend[int'(bus.i_issue_rd)] = int'(bus.i_issue_rob_pos);
      end
    end
  endtask

  task automatic model_read(input logic [4:0] rs, output logic [31:0] v, output logic b, output logic [3:0] p);
    int r;
    r = int'(rs);
    v = m_val[r]; b = (m_pend[r] >= 0); p = b ? 4'(m_pend[r]) : 4'd0;
    if (r == 0) begin
      v = '0; b = 1'b0; p = '0;
    end else if (b && bus.i_reg_write && bus.i_reg_rd == rs && m_pend[r] == int'(bus.i_commit_rob_pos)) begin
      v = bus.i_reg_val; b = 1'b0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_pend[i] = -1;
    end
  endtask

  initial begin
    logic [31:0] ev1, ev2;
    logic        eb1, eb2;
    logic [3:0]  ep1, ep2;
    int          rd;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    idle();
    bus.i_rs1 = 5'd5;
    #2;
    chk_port("reset_rs1", bus.o_rs1_val, bus.o_rs1_busy, bus.o_rs1_rob_pos, 32'd0, 1'b0, 4'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // rdy rb iss ird ipos  rs  wr wrd wval cpos  -> exp val busy pos
    add(1,0,0,5'd0,4'd0, 5'd6, 1,5'd6,32'h55,4'd0,   32'h0,0,4'd0);
    add(1,0,1,5'd3,4'd7, 5'd3, 0,5'd0,32'h0,4'd0,    32'h0,0,4'd0);
    add(1,0,0,5'd0,4'd0, 5'd3, 0,5'd0,32'h0,4'd0,    32'h0,1,4'd7);
    add(1,0,0,5'd0,4'd0, 5'd3, 1,5'd3,32'hDEADBEEF,4'd7, 32'hDEADBEEF,0,4'd0);
    add(1,0,0,5'd0,4'd0, 5'd3, 0,5'd0,32'h0,4'd0,    32'hDEADBEEF,0,4'd0);
    add(1,0,1,5'd4,4'd2, 5'd4, 0,5'd0,32'h0,4'd0,    32'h0,0,4'd0);
    add(1,0,1,5'd4,4'd5, 5'd4, 0,5'd0,32'h0,4'd0,    32'h0,1,4'd2);
    add(1,0,0,5'd0,4'd0, 5'd4, 1,5'd4,32'd11,4'd2,   32'h0,1,4'd5);
    add(1,0,0,5'd0,4'd0, 5'd4, 0,5'd0,32'h0,4'd0,    32'd11,1,4'd5);
    add(1,0,1,5'd6,4'd9, 5'd6, 0,5'd0,32'h0,4'd0,    32'h55,0,4'd0);
    add(1,0,0,5'd0,4'd0, 5'd6, 0,5'd0,32'h0,4'd0,    32'h55,1,4'd9);
    add(1,0,1,5'd0,4'd1, 5'd0, 1,5'd0,32'h123,4'd1,  32'h0,0,4'd0);
    add(1,0,0,5'd0,4'd0, 5'd0, 0,5'd0,32'h0,4'd0,    32'h0,0,4'd0);
    add(0,0,1,5'd2,4'd3, 5'd2, 0,5'd0,32'h0,4'd0,    32'h0,0,4'd0);
    add(1,0,0,5'd0,4'd0, 5'd2, 0,5'd0,32'h0,4'd0,    32'h0,0,4'd0);
    add(1,0,1,5'd3,4'd12,5'd3, 1,5'd3,32'h77,4'd7,   32'hDEADBEEF,0,4'd0);
    add(1,0,0,5'd0,4'd0, 5'd3, 0,5'd0,32'h0,4'd0,    32'h77,1,4'd12);

    foreach (tbl[k]) begin
      bus.i_rdy = tbl[k].rdy; bus.i_rollback = tbl[k].rb; bus.i_issue = tbl[k].iss;
      bus.i_issue_rd = tbl[k].ird; bus.i_issue_rob_pos = tbl[k].ipos;
      bus.i_rs1 = tbl[k].rs; bus.i_rs2 = tbl[k].rs;
      bus.i_reg_write = tbl[k].wr; bus.i_reg_rd = tbl[k].wrd; bus.i_reg_val = tbl[k].wval;
      bus.i_commit_rob_pos = tbl[k].cpos;
      @(negedge clk);
      chk_port($sformatf("vec%0d_rs1", k), bus.o_rs1_val, bus.o_rs1_busy, bus.o_rs1_rob_pos,
               tbl[k].e_val, tbl[k].e_busy, tbl[k].e_pos, tbl[k].e_busy || tbl[k].rs == 0);
      chk_port($sformatf("vec%0d_rs2", k), bus.o_rs2_val, bus.o_rs2_busy, bus.o_rs2_rob_pos,
               tbl[k].e_val, tbl[k].e_busy, tbl[k].e_pos, tbl[k].e_busy || tbl[k].rs == 0);
      @(posedge clk); #1;
    end

    // Rollback with a concurrent commit and issue.
    idle(); bus.i_issue = 1'b1; bus.i_issue_rd = 5'd1; bus.i_issue_rob_pos = 4'd3;
    @(posedge clk); #1;
    bus.i_issue_rd = 5'd2; bus.i_issue_rob_pos = 4'd4;
    @(posedge clk); #1;
    bus.i_rollback = 1'b1; bus.i_issue_rd = 5'd8; bus.i_issue_rob_pos = 4'd6;
    bus.i_reg_write = 1'b1; bus.i_reg_rd = 5'd1; bus.i_reg_val = 32'h80; bus.i_commit_rob_pos = 4'd3;
    bus.i_rs1 = 5'd1; bus.i_rs2 = 5'd2;
    @(negedge clk);
    chk_port("rb_pre_x1", bus.o_rs1_val, bus.o_rs1_busy, bus.o_rs1_rob_pos, 32'h80, 1'b0, 4'd0, 1'b0);
    chk_port("rb_pre_x2", bus.o_rs2_val, bus.o_rs2_busy, bus.o_rs2_rob_pos, 32'h0, 1'b1, 4'd4, 1'b1);
    @(posedge clk); #1;
    idle(); bus.i_rs1 = 5'd1; bus.i_rs2 = 5'd2;
    @(negedge clk);
    chk_port("rb_x1", bus.o_rs1_val, bus.o_rs1_busy, bus.o_rs1_rob_pos, 32'h80, 1'b0, 4'd0, 1'b0);
    chk_port("rb_x2", bus.o_rs2_val, bus.o_rs2_busy, bus.o_rs2_rob_pos, 32'h0, 1'b0, 4'd0, 1'b0);
    bus.i_rs1 = 5'd8; bus.i_rs2 = 5'd6;
    #1;
    chk_port("rb_x8", bus.o_rs1_val, bus.o_rs1_busy, bus.o_rs1_rob_pos, 32'h0, 1'b0, 4'd0, 1'b0);
    chk_port("rb_x6", bus.o_rs2_val, bus.o_rs2_busy, bus.o_rs2_rob_pos, 32'h55, 1'b0, 4'd0, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset clears a live mapping without a clock edge.
    idle(); bus.i_issue = 1'b1; bus.i_issue_rd = 5'd5; bus.i_issue_rob_pos = 4'd1;
    @(posedge clk); #1;
    idle(); bus.i_rs1 = 5'd5;
    @(negedge clk);
    chk_port("areset_pre", bus.o_rs1_val, bus.o_rs1_busy, bus.o_rs1_rob_pos, 32'h0, 1'b1, 4'd1, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk_port("areset_x5", bus.o_rs1_val, bus.o_rs1_busy, bus.o_rs1_rob_pos, 32'h0, 1'b0, 4'd0, 1'b1);
    bus.i_rs1 = 5'd3; bus.i_rs2 = 5'd4;
    #1;
    chk_port("areset_x3", bus.o_rs1_val, bus.o_rs1_busy, bus.o_rs1_rob_pos, 32'h0, 1'b0, 4'd0, 1'b0);
    chk_port("areset_x4", bus.o_rs2_val, bus.o_rs2_busy, bus.o_rs2_rob_pos, 32'h0, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;

    // Random traffic on a small register window against the mapping model.
    for (int c = 0; c < 3000; c++) begin
      bus.i_rdy        = ($urandom_range(0, 7) != 0);
      bus.i_rollback   = ($urandom_range(0, 15) == 0);
      bus.i_issue      = $urandom_range(0, 1);
      bus.i_issue_rd   = 5'($urandom_range(0, 7));
      bus.i_issue_rob_pos = 4'($urandom);
      bus.i_rs1        = 5'($urandom_range(0, 7));
      bus.i_rs2        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      bus.i_reg_write  = $urandom_range(0, 1);
      bus.i_reg_rd     = ($urandom_range(0, 1) == 0) ? bus.i_rs1 : 5'($urandom_range(0, 7));
      bus.i_reg_val    = $urandom;
      rd = int'(bus.i_reg_rd);
      bus.i_commit_rob_pos = (m_pend[rd] >= 0 && $urandom_range(0, 3) != 0) ? 4'(m_pend[rd]) : 4'($urandom);
      @(negedge clk);
      model_read(bus.i_rs1, ev1, eb1, ep1);
      model_read(bus.i_rs2, ev2, eb2, ep2);
      chk_port("rnd_rs1", bus.o_rs1_val, bus.o_rs1_busy, bus.o_rs1_rob_pos, ev1, eb1, ep1, eb1 || bus.i_rs1 == 0);
      chk_port("rnd_rs2", bus.o_rs2_val, bus.o_rs2_busy, bus.o_rs2_rob_pos, ev2, eb2, ep2, eb2 || bus.i_rs2 == 0);
      @(posedge clk);
      model_tick();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
